// File: rtl/text_pkg.sv
// Shared constants for the text-mode renderer: cell geometry, blank glyph code
// and default RGB444 colours.
package text_pkg;
   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;
   localparam logic [6:0] CHAR_SPACE = 7'h20;
   localparam logic [11:0] RGB_WHITE = 12'hFFF;
   localparam logic [11:0] RGB_BLACK = 12'h000;
   localparam int COL_W = 7;
   localparam int ROW_W = 5;
   localparam int CODE_W = 7;
endpackage

// File: rtl/text_buffer.sv
// Character RAM: one write port, one synchronous read-first read port.
// Content powers up as spaces and is deliberately untouched by reset.
module text_buffer
   import text_pkg::*;
#(
   parameter int DEPTH = 2400,
   parameter int AW    = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [CODE_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [CODE_W-1:0] rdata
);
   logic [CODE_W-1:0] mem [DEPTH] = '{default: CHAR_SPACE};

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Non-blocking read of the array gives old data on a same-address write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
   end
endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel generator: cell lookup, glyph ROM drive, pixel serialise and
// blinking cursor overlay. Pixel position to rgb latency is two clocks.
module text_renderer
   import text_pkg::*;
#(
   parameter int          COLS         = 80,
   parameter int          ROWS         = 30,
   parameter int          BLINK_CYCLES = 25000000,
   parameter logic [11:0] FG_COLOR     = RGB_WHITE,
   parameter logic [11:0] BG_COLOR     = RGB_BLACK
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              video_on,
   input  logic              wr_en,
   input  logic [COL_W-1:0]  wr_col,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [CODE_W-1:0] wr_char,
   input  logic              cursor_en,
   input  logic [COL_W-1:0]  cursor_col,
   input  logic [ROW_W-1:0]  cursor_row,
   output logic [CODE_W-1:0] char_code,
   output logic [3:0]        row,
   input  logic [7:0]        char_line,
   output logic [11:0]       rgb,
   output logic              video_on_out
);
   localparam int DEPTH = COLS * ROWS;
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [6:0] COLS_L = 7'(COLS);
   localparam logic [5:0] ROWS_L = 6'(ROWS);

   // stage 0: cell decode
   logic [6:0]        cell_col;
   logic [5:0]        cell_row;
   logic              oor, cur_hit, wr_ok;
   logic [AW-1:0]     rd_addr, wr_addr;
   logic [CODE_W-1:0] rd_data;

   assign cell_col = pixel_x[9:3];
   assign cell_row = pixel_y[9:4];
   assign oor      = (cell_col >= COLS_L) || (cell_row >= ROWS_L);
   assign cur_hit  = cursor_en && (cell_col == cursor_col) &&
                     (cell_row == {1'b0, cursor_row});
   // Out-of-range cells read address 0; the data is masked in stage 1 anyway.
   assign rd_addr  = oor ? '0 : AW'(cell_row) * AW'(COLS) + AW'(cell_col);
   assign wr_ok    = wr_en && ({1'b0, wr_row} < ROWS_L) && (wr_col < COLS_L);
   assign wr_addr  = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

   text_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok),
      .waddr (wr_addr),
      .wdata (wr_char),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // stage 1 registers; vld_pipe[1] is stage-1 video_on, [2] drives the pin
   logic [2:0] bit_idx_q;
   logic [3:0] glyph_row_q;
   logic       oor_q, hit_q;
   logic [2:1] vld_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx_q   <= '0;
         glyph_row_q <= '0;
         oor_q       <= 1'b0;
         hit_q       <= 1'b0;
         vld_pipe    <= '0;
      end else begin
         bit_idx_q   <= pixel_x[2:0];
         glyph_row_q <= pixel_y[3:0];
         oor_q       <= oor;
         hit_q       <= cur_hit;
         vld_pipe    <= {vld_pipe[1], video_on};
      end
   end

   assign char_code    = oor_q ? '0 : rd_data;
   assign row          = glyph_row_q;
   assign video_on_out = vld_pipe[2];

   // cursor blink timebase
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // stage 2: serialise glyph line, bit 7 is the leftmost pixel
   logic pix;
   assign pix = char_line[3'd7 - bit_idx_q] ^ (hit_q & blink_phase);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           rgb <= '0;
      else if (vld_pipe[1]) rgb <= pix ? FG_COLOR : BG_COLOR;
      else                  rgb <= '0;
   end
endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer with a small arithmetic glyph ROM model.
module tb_text_renderer;
   localparam logic [11:0] FG = 12'hFFF;
   localparam logic [11:0] BG = 12'h00A;

   logic        clk, rst_n;
   logic [9:0]  pixel_x, pixel_y;
   logic        video_on, wr_en, cursor_en;
   logic [6:0]  wr_col, wr_char, cursor_col;
   logic [4:0]  wr_row, cursor_row;
   logic [6:0]  char_code;
   logic [3:0]  row;
   logic [7:0]  char_line;
   logic [11:0] rgb;
   logic        video_on_out;

   int checks = 0;
   int errors = 0;
   int unsigned ecount;

   text_renderer #(
      .COLS(80), .ROWS(30), .BLINK_CYCLES(4), .FG_COLOR(FG), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .video_on(video_on), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
      .wr_char(wr_char), .cursor_en(cursor_en), .cursor_col(cursor_col),
      .cursor_row(cursor_row), .char_code(char_code), .row(row),
      .char_line(char_line), .rgb(rgb), .video_on_out(video_on_out)
   );

   // glyph ROM stand-in: code 0 is blank, others mix code and line number
   function automatic logic [7:0] glyph(input logic [6:0] c, input logic [3:0] r);
      return (c == 7'd0) ? 8'h00 : ({1'b0, c} ^ {r, r});
   endfunction
   assign char_line = glyph(char_code, row);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // clock edges since reset release, used to predict the blink phase
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecount <= 0;
      else        ecount <= ecount + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic px(input int x, input int y, input logic vo);
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = vo;
   endtask

   task automatic wr(input int c, input int r, input logic [6:0] ch);
      wr_en = 1'b1; wr_col = 7'(c); wr_row = 5'(r); wr_char = ch;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0;
      cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
      px(0, 0, 1'b0);
      #2;
      chk("rst_rgb", rgb, 12'h000);
      chk("rst_vout", video_on_out, 1'b0);
      chk("rst_code", char_code, 7'h00);
      chk("rst_row", row, 4'h0);
      step();
      rst_n = 1'b1;
      step();

      // 'A' at cell (0,0); glyph line 5 = 0x14, bit_idx 3 -> line[4]=1
      wr(0, 0, 7'h41);
      px(3, 5, 1'b1);
      step();
      chk("a_code", char_code, 7'h41);
      chk("a_row", row, 4'h5);
      px(0, 5, 1'b1);
      step();
      chk("a_rgb_fg", rgb, FG);
      chk("a_vout", video_on_out, 1'b1);
      step();
      chk("a_rgb_bg", rgb, BG);

      // blanking forces black even on a lit glyph pixel
      px(3, 5, 1'b0);
      step(); step();
      chk("voff_rgb", rgb, 12'h000);
      chk("voff_vout", video_on_out, 1'b0);

      // out-of-range cells read as code 0
      px(640, 0, 1'b1);
      step();
      chk("oor_col", char_code, 7'h00);
      px(0, 480, 1'b1);
      step();
      chk("oor_row", char_code, 7'h00);
      wr(80, 0, 7'h55);
      px(0, 16, 1'b1);
      step();
      chk("oor_wr_drop", char_code, 7'h20);

      // same-cycle write and read of one cell returns the old code
      px(16, 48, 1'b1);
      wr_en = 1'b1; wr_col = 7'd2; wr_row = 5'd3; wr_char = 7'h42;
      step();
      wr_en = 1'b0;
      chk("coll_old", char_code, 7'h20);
      step();
      chk("coll_new", char_code, 7'h42);

      // async reset mid-line clears outputs before any edge
      px(3, 5, 1'b1);
      step(); step();
      chk("pre_rst_fg", rgb, FG);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rgb", rgb, 12'h000);
      chk("mid_rst_vout", video_on_out, 1'b0);
      chk("mid_rst_code", char_code, 7'h00);
      px(0, 0, 1'b0);
      step();
      rst_n = 1'b1;
      px(3, 5, 1'b1);
      step();
      chk("rel_vout_t1", video_on_out, 1'b0);
      step();
      chk("rel_vout_t2", video_on_out, 1'b1);
      chk("rel_rgb_t2", rgb, FG);

      // cursor at (2,1) over a blank pixel: blink every 4 clocks
      cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 5'd1;
      px(16, 16, 1'b1);
      step(); step();
      for (int i = 0; i < 12; i++) begin
         step();
         chk($sformatf("blink%0d", i), rgb, (((ecount - 1) >> 2) & 1) != 0 ? FG : BG);
      end
      cursor_en = 1'b0;
      step(); step();
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("nocur%0d", i), rgb, BG);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Text-mode pixel generator for the VGA path; the consumer side of the 8x16 glyph ROM interface (char_code/row out, char_line in).
- Holds a COLS x ROWS character buffer written by the host logic.
- For each scan pixel it looks up the character, drives the glyph ROM, serialises the returned line into colour pixels, and overlays a blinking cursor.
- Sits between the VGA sync generator (pixel_x/pixel_y/video_on) and the RGB output pins; clk is the pixel clock.

Parameters:
- COLS, 80, text columns
- ROWS, 30, text rows
- BLINK_CYCLES, 25000000, clk cycles per cursor blink half-period
- FG_COLOR, 12'hFFF, foreground RGB444
- BG_COLOR, 12'h000, background RGB444

Ports:
- clk  in  1  pixel clock, one pixel per cycle
- rst_n  in  1  asynchronous active-low reset
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan line
- video_on  in  1  visible-area flag aligned with pixel_x/pixel_y
- wr_en  in  1  character buffer write strobe
- wr_col  in  7  write column
- wr_row  in  5  write row
- wr_char  in  7  ASCII code to store
- cursor_en  in  1  cursor display enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- char_code  out  7  ASCII code to glyph ROM
- row  out  4  glyph line to glyph ROM
- char_line  in  8  glyph ROM line; combinational response; bit 7 = leftmost pixel
- rgb  out  12  pixel colour
- video_on_out  out  1  video_on delayed to align with rgb

Behaviour:
- Reset (async assert, sync deassert by the clk domain): rgb=0, video_on_out=0, char_code=0, row=0, all pipeline registers 0, blink counter 0, blink_phase 0. The buffer is not cleared by reset; its power-up content is 7'h20 (space).
- Buffer: COLS*ROWS x 7 bits, address = row*COLS+col, synchronous read, read-first on same-address collision.
- Writes with wr_col>=COLS or wr_row>=ROWS are dropped.
- Stage 0 (cycle t): cell_col=pixel_x>>3, cell_row=pixel_y>>4. Issue buffer read. Register the following into stage 1:
  - bit_idx=pixel_x[2:0]
  - glyph_row=pixel_y[3:0]
  - video_on
  - oor = (cell_col>=COLS) or (cell_row>=ROWS)
  - cur_hit = cursor_en & cell_col==cursor_col & cell_row==cursor_row
- Stage 1 (t+1): char_code = oor ? 0 : buffer data; row = glyph_row. Both are registered/combinational such that they change only on clk edges.
- Stage 2 (t+2): pix = char_line[7-bit_idx] ^ (cur_hit & blink_phase). Then rgb = video_on_d ? (pix ? FG_COLOR : BG_COLOR) : 0, and video_on_out = video_on_d.
- Latency pixel_x/pixel_y -> rgb is exactly 2 cycles; no stalls or back-pressure.
- Blink: the counter runs 0..BLINK_CYCLES-1 continuously. blink_phase toggles on the cycle the counter wraps to 0.
- Cursor inverts the whole 8x16 cell while blink_phase=1.
- Changes to cursor_col/cursor_row/cursor_en take effect for pixels sampled at stage 0 on or after the change.
- video_on=0 forces rgb=0 regardless of buffer or cursor.

Decomposition:
- Package text_pkg:
  - CHAR_W=8, CHAR_H=16
  - CHAR_SPACE=7'h20
  - RGB444 colour constants
  - cell index widths
- Sub-module text_buffer: simple dual-port RAM with one write port and one synchronous read-first read port, initialised to CHAR_SPACE.
- The glyph ROM is instantiated by the parent, not inside this block.

Test Plan:
- Reset: assert rst_n=0 mid-line with rgb=FG -> rgb=0 and video_on_out=0 immediately, before the next clk edge. After release the first valid rgb appears 2 cycles after the first video_on=1.
- Write 7'h41 at (col 0,row 0), then drive pixel (3,5) with video_on=1 at t -> char_code=7'h41, row=5 at t+1; rgb=FG iff char_line[4]=1 at t+2, else BG.
- Out-of-range: pixel_x=640 (cell 80), video_on=1 -> char_code=0 at t+1. Write to wr_col=80 -> readback of (0,1) is unchanged.
- Collision: in the same cycle write 7'h42 to (2,3) and read pixel in cell (2,3) -> char_code shows old value. The next read of that cell shows 7'h42.
- Blink with BLINK_CYCLES=4, cursor_en=1 at (2,1), constant pixel in that cell -> rgb alternates inverted/normal every 4 cycles. With cursor_en=0 there is no inversion.
- video_on=0 with FG glyph bits -> rgb=0 at t+2.
